pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. It is the wide successor to the fixed 16-bit combinational CLA. It splits a WIDTH-bit add across STAGES register stages, with a valid/ready handshake on both sides. The execute stage and the cache address/tag arithmetic use it wherever a single-cycle wide add misses timing.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
STAGES, 2, number of pipeline register stages (latency); 1 <= STAGES <= WIDTH/4, and (WIDTH/4) % STAGES == 0.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands presented this cycle
in_ready  output  1  block can accept operands this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in (ignored when in_sub=1)
in_sub  input  1  1: A - B (B inverted, carry-in forced 1); 0: A + B + cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
out_sum  output  WIDTH  result
out_cout  output  1  carry out of MSB (for sub: 1 = no borrow)
out_ovf  output  1  signed overflow
out_zero  output  1  out_sum == 0

Behaviour:
- Reset (rst=1 at a rising edge): all stage valid bits cleared and all stage data registers cleared. After reset: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0 (zero flag qualified by out_valid), in_ready=1. rst overrides any concurrent handshake. In-flight operations are discarded, not completed.
- Group split:
  - GROUPS = WIDTH/4; each stage handles GPS = GROUPS/STAGES consecutive groups, LSB groups first.
  - Within a stage, each group generates a 4-bit P/G. A second-level lookahead over the GPS groups produces the group carries in one level (no ripple between groups inside a stage).
- Stage k register holds:
  - the partial sum bits completed so far;
  - the remaining unprocessed A and B' bits (B' = B, or ~B when sub);
  - the carry into the next group;
  - the MSB operand signs, for overflow;
  - a valid bit v[k].
- Final stage outputs:
  - out_sum;
  - out_cout = carry out of group GROUPS-1;
  - out_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]);
  - out_zero = ~|out_sum.
- Latency: exactly STAGES cycles from accepted input to out_valid when there is no backpressure. Throughput is one result per cycle.
- Handshake:
  - Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - Stage readiness: r[STAGES-1] = out_ready || !v[STAGES-1]; r[k] = r[k+1] || !v[k]; in_ready = r[0]. The ready chain is combinational.
  - Stage k loads from upstream when r[k]=1. Its valid becomes the upstream valid, so bubbles are squeezed.
  - When r[k]=0, stage k holds its data and valid unchanged.
- Output stability: while out_valid=1 and out_ready=0, out_sum/cout/ovf/zero must not change.
- Simultaneous events: full pipeline with out_ready=1 and in_valid=1 accepts a new input and emits a result in the same cycle, with no lost cycle.
- Arithmetic is modulo 2^WIDTH. No sign extension; the carry is reported only through out_cout.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- When defined:
  - Adds input in_sat (1 bit), carried through the pipeline with the operands.
  - If in_sat=1 and signed overflow occurs, out_sum is clamped to the maximum positive value (0x7FFF_FFFF for WIDTH=32) when A[MSB]=0, or the minimum negative value (0x8000_0000) when A[MSB]=1.
  - out_ovf still reports the overflow; out_zero reflects the clamped value.
- When undefined: no in_sat port, and results always wrap.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, out_sum=0, in_ready=1. Release rst with in_valid=0 for 5 cycles -> out_valid stays 0.
- Add with full carry chain: in_a=32'hFFFF_FFFF, in_b=32'h0000_0001, cin=0, sub=0 -> 2 cycles later out_sum=0, out_cout=1, out_zero=1, out_ovf=0.
- Subtract with signed overflow: in_a=32'h8000_0000, in_b=32'h0000_0001, sub=1 -> out_sum=32'h7FFF_FFFF, out_ovf=1, out_cout=1. With CLA_SATURATE_EN and in_sat=1 -> out_sum=32'h8000_0000, out_ovf=1.
- Back-to-back stream: 8 consecutive inputs a=i, b=i*3, in_valid=1, out_ready=1 -> results 4*i on 8 consecutive cycles starting at cycle 2, with in_ready=1 throughout.
- Backpressure:
  - Stream 4 ops with out_ready=0 -> in_ready drops after 2 accepts (STAGES=2), and out_sum is held stable.
  - Raise out_ready -> all 4 results appear in order; none lost or duplicated.
- Reset mid-operation: 2 ops in flight, assert rst for 1 cycle -> next cycle out_valid=0 and no stale result ever appears. Sweep STAGES=1,4,8 at WIDTH=32 against a reference model.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, valid/ready on both sides.
// Optional saturation on signed overflow is enabled by defining CLA_SATURATE_EN (adds the in_sat port).
module pipelined_cla_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
`ifdef CLA_SATURATE_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned GROUPS = WIDTH / 4;
  localparam int unsigned GPS    = GROUPS / STAGES;
  localparam int unsigned SW     = 4 * GPS;
  localparam int unsigned MSB    = WIDTH - 1;
  localparam int unsigned LAST   = STAGES - 1;
  // Operand registers exist only for stages that still feed a later stage.
  localparam int unsigned PIPE   = (STAGES > 1) ? STAGES - 1 : 1;

  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
  logic [PIPE-1:0][WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [PIPE-1:0]              sat_q, sat_d;
  logic [STAGES-1:0]            v_q, v_d, c_q, c_d, r;
  logic                         ovf_q, ovf_d, zero_q, zero_d;
  logic                         sat_in;

`ifdef CLA_SATURATE_EN
  assign sat_in = in_sat;
`else
  assign sat_in = 1'b0;
`endif

  // Stage k may advance when it is empty or some stage downstream of it can drain.
  always_comb begin
    r = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      logic acc;
      acc = out_ready;
      for (int unsigned j = k; j < STAGES; j++) acc = acc | ~v_q[j];
      r[k] = acc;
    end
  end

  always_comb begin
    s_d    = '0;
    a_d    = '0;
    b_d    = '0;
    sat_d  = '0;
    v_d    = '0;
    c_d    = '0;
    ovf_d  = 1'b0;
    zero_d = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      logic [WIDTH-1:0] sa, sb, ss;
      logic             sc, sv, st, acc, term;
      logic [SW-1:0]    p, g, bc;
      logic [GPS-1:0]   gp, gg;
      logic [GPS:0]     gc;
      int unsigned      km1, kk;
      km1 = (k == 0) ? 0 : k - 1;
      kk  = (k < PIPE) ? k : 0;
      if (k == 0) begin
        sa = in_a;
        sb = in_sub ? ~in_b : in_b;
        ss = '0;
        sc = in_sub | in_cin;
        sv = in_valid;
        st = sat_in;
      end else begin
        sa = a_q[km1];
        sb = b_q[km1];
        ss = s_q[km1];
        sc = c_q[km1];
        sv = v_q[km1];
        st = sat_q[km1];
      end
      p = sa[k*SW +: SW] ^ sb[k*SW +: SW];
      g = sa[k*SW +: SW] & sb[k*SW +: SW];
      for (int unsigned j = 0; j < GPS; j++) begin
        gp[j] = &p[4*j +: 4];
        gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (&p[4*j+2 +: 2] & g[4*j+1])
              | (&p[4*j+1 +: 3] & g[4*j]);
      end
      // Second-level lookahead: every group carry is a flat sum of products.
      gc    = '0;
      gc[0] = sc;
      for (int unsigned j = 1; j <= GPS; j++) begin
        acc = sc;
        for (int unsigned n = 0; n < j; n++) acc = acc & gp[n];
        for (int unsigned m = 0; m < j; m++) begin
          term = gg[m];
          for (int unsigned n = m + 1; n < j; n++) term = term & gp[n];
          acc = acc | term;
        end
        gc[j] = acc;
      end
      bc = '0;
      for (int unsigned j = 0; j < GPS; j++) begin
        for (int unsigned i = 0; i < 4; i++) begin
          acc = gc[j];
          for (int unsigned n = 0; n < i; n++) acc = acc & p[4*j+n];
          for (int unsigned m = 0; m < i; m++) begin
            term = g[4*j+m];
            for (int unsigned n = m + 1; n < i; n++) term = term & p[4*j+n];
            acc = acc | term;
          end
          bc[4*j+i] = acc;
        end
      end
      ss[k*SW +: SW] = p ^ bc;
      if (k == LAST) begin
        ovf_d = (sa[MSB] == sb[MSB]) && (ss[MSB] != sa[MSB]);
        if (ovf_d && st)
          ss = sa[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        zero_d = sv && (ss == '0);
      end else begin
        a_d[kk]   = sa;
        b_d[kk]   = sb;
        sat_d[kk] = st;
      end
      s_d[k] = ss;
      c_d[k] = gc[GPS];
      v_d[k] = sv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sat_q  <= '0;
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (r[k]) begin
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
          v_q[k] <= v_d[k];
          if (k < LAST) begin
            a_q[(k < PIPE) ? k : 0]   <= a_d[(k < PIPE) ? k : 0];
            b_q[(k < PIPE) ? k : 0]   <= b_d[(k < PIPE) ? k : 0];
            sat_q[(k < PIPE) ? k : 0] <= sat_d[(k < PIPE) ? k : 0];
          end
        end
      end
      if (r[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign in_ready  = r[0];
  assign out_valid = v_q[LAST];
  assign out_sum   = s_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: driver pushes expected results, monitor pops on output transfers.
module tb_pipelined_cla_adder;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;
`ifdef CLA_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_cin, in_sub;
  logic [WIDTH-1:0] in_a, in_b;
`ifdef CLA_SATURATE_EN
  logic             in_sat;
`endif
  logic             out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [WIDTH-1:0] out_sum;

  pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
`ifdef CLA_SATURATE_EN
    .in_sat(in_sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    longint           cyc;
  } exp_t;

  exp_t             q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  longint           cyc = 0;
  bit               strict_lat = 1'b0;
  bit               held_v = 1'b0;
  logic [WIDTH-1:0] held_sum;
  logic             held_cout, held_ovf, held_zero;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub, input logic sat);
    exp_t   e;
    longint sa, sb, ua, ub, tru, maxs, mins;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = longint'(a);
    ub   = longint'(b);
    maxs = (longint'(1) <<< (WIDTH - 1)) - 1;
    mins = -(longint'(1) <<< (WIDTH - 1));
    if (sub) begin
      tru    = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      tru    = sa + sb + longint'(cin);
      e.cout = ((ua + ub + longint'(cin)) >>> WIDTH) != 0;
    end
    e.ovf = (tru > maxs) || (tru < mins);
    e.sum = WIDTH'(tru);
    if (SAT_EN && sat && e.ovf) e.sum = a[WIDTH-1] ? WIDTH'(mins) : WIDTH'(maxs);
    e.zero = (e.sum == '0);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic idle(input int n, input logic ordy);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = ordy;
    end
  endtask

  task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                       input logic sub, input logic sat, input logic ordy, output bit acc);
    exp_t e;
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
`ifdef CLA_SATURATE_EN
    in_sat    = sat;
`endif
    in_valid  = 1'b1;
    out_ready = ordy;
    #1;
    acc = in_ready;
    if (acc) begin
      e     = model(a, b, cin, sub, sat);
      e.cyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                      input logic sub, input logic sat);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      offer(a, b, cin, sub, sat, 1'b1, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  // Monitor: compare on every output transfer and watch held outputs under backpressure.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_sum", longint'(out_sum), longint'(held_sum));
        check("hold_flags", longint'({out_cout, out_ovf, out_zero}),
              longint'({held_cout, held_ovf, held_zero}));
      end
      held_v = 1'b0;
      if (out_valid && !out_ready) begin
        held_v    = 1'b1;
        held_sum  = out_sum;
        held_cout = out_cout;
        held_ovf  = out_ovf;
        held_zero = out_zero;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_output", longint'(out_sum), -1);
        end else begin
          e = q.pop_front();
          check("sum", longint'(out_sum), longint'(e.sum));
          check("cout", longint'(out_cout), longint'(e.cout));
          check("ovf", longint'(out_ovf), longint'(e.ovf));
          check("zero", longint'(out_zero), longint'(e.zero));
          if (strict_lat) check("latency", cyc - e.cyc, longint'(STAGES));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ops_a[4];
    logic [WIDTH-1:0] ops_b[4];
    logic [WIDTH-1:0] ra, rb;
    bit               acc;
    int               idx;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
`ifdef CLA_SATURATE_EN
    in_sat    = 1'b0;
`endif
    idle(2, 1'b1);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_sum", longint'(out_sum), 0);
    check("rst_flags", longint'({out_cout, out_ovf, out_zero}), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    rst = 1'b0;
    repeat (5) begin
      idle(1, 1'b1);
      #1;
      check("idle_out_valid", longint'(out_valid), 0);
    end

    // Directed corner cases
    strict_lat = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0006, 1'b1, 1'b1, 1'b0);
    send(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    idle(STAGES + 3, 1'b1);

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      offer(WIDTH'(i), WIDTH'(i * 3), 1'b0, 1'b0, 1'b0, 1'b1, acc);
      check("stream_in_ready", longint'(acc), 1);
    end
    idle(STAGES + 3, 1'b1);

    // Backpressure: only STAGES operations fit while the output is stalled
    strict_lat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = WIDTH'($urandom);
      ops_b[i] = WIDTH'($urandom);
    end
    idx = 0;
    repeat (6) begin
      if (idx < 4) begin
        offer(ops_a[idx], ops_b[idx], 1'b0, 1'b0, 1'b0, 1'b0, acc);
        if (acc) idx++;
      end else begin
        idle(1, 1'b0);
      end
    end
    check("bp_accepts", longint'(idx), longint'((STAGES < 4) ? STAGES : 4));
    #1;
    check("bp_in_ready", longint'(in_ready), (STAGES <= 4) ? 0 : 1);
    while (idx < 4) begin
      send(ops_a[idx], ops_b[idx], 1'b0, 1'b0, 1'b0);
      idx++;
    end
    idle(STAGES + 4, 1'b1);
    check("bp_drained", longint'(q.size()), 0);

    // Reset with operations in flight
    offer(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    offer(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    idle(STAGES + 4, 1'b1);

    // Random traffic with random backpressure
    repeat (600) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = {1'b1, {(WIDTH-1){1'b0}}};
        2: ra = {1'b0, {(WIDTH-1){1'b1}}};
        3: rb = ra;
        default: ;
      endcase
      if ($urandom_range(0, 3) != 0)
        offer(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), acc);
      else
        idle(1, 1'($urandom_range(0, 3) != 0));
    end
    idle(STAGES + 20, 1'b1);
    check("final_drained", longint'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
